tm1638_frame_driver: RTL

- Downstream consumer of the 8-bit counter stage: takes its two byte outputs (val0, val1) and shows them as four hex digits on a TM1638 board.
- Serialises a full TM1638 write frame in auto-increment mode on the STB/CLK/DIO pins: data command, address + 16 data bytes, display-control command.
- Write-only; DIO is always driven and never turned around.

---
 rtl/tm1638_frame_driver.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_frame_driver.sv
// TM1638 frame writer: shows val1:val0 as four hex digits using one auto-increment
// frame (data command, address + 16 bytes, display control) on STB/CLK/DIO.
module tm1638_frame_driver #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [2:0]  BRIGHT  = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    output logic       busy,
    output logic       done,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 3;
    localparam int unsigned ADR_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = 3'd7;
    localparam logic [ADR_W-1:0]  ADR_LAST = 4'hF;
    localparam logic [BYTE_W-1:0] CMD_DATA = 8'h40;
    localparam logic [BYTE_W-1:0] CMD_ADDR = 8'hC0;
    localparam logic [BYTE_W-1:0] CMD_DISP = {5'b10001, BRIGHT};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD1 = 3'd1;
    localparam logic [2:0] S_GAP1 = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_GAP2 = 3'd5;
    localparam logic [2:0] S_CMD3 = 3'd6;
    localparam logic [2:0] S_GAP3 = 3'd7;

    logic [2:0]        state,    state_n;
    logic [DIV_W-1:0]  div_cnt,  div_n;
    logic              setup,    setup_n;
    logic              clk_lo,   clk_lo_n;
    logic [BIT_W-1:0]  bit_cnt,  bit_n;
    logic [ADR_W-1:0]  byte_cnt, byte_n;
    logic [BYTE_W-1:0] sh,       sh_n;
    logic [BYTE_W-1:0] lat0,     lat0_n;
    logic [BYTE_W-1:0] lat1,     lat1_n;
    logic              busy_n, done_n, stb_n, sclk_n, dio_n;
    logic              tick, slot_n;

    // Seven-segment pattern, dp=bit7 off, gfedcba in bits 6..0.
    function automatic logic [BYTE_W-1:0] hex7(input logic [3:0] nib);
        logic [BYTE_W-1:0] seg;
        seg = 8'h00;
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    // Display RAM content: even addresses 0,2,4,6 are grids 1..4, everything else blank.
    function automatic logic [BYTE_W-1:0] ram_byte(input logic [ADR_W-1:0] adr,
                                                   input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
        logic [3:0]        nib;
        logic [BYTE_W-1:0] res;
        nib = 4'h0;
        case (adr[2:1])
            2'd0:    nib = hi[7:4];
            2'd1:    nib = hi[3:0];
            2'd2:    nib = lo[7:4];
            default: nib = lo[3:0];
        endcase
        res = (adr[0] || adr[3]) ? 8'h00 : hex7(nib);
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            setup    <= 1'b0;
            clk_lo   <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sh       <= '0;
            lat0     <= '0;
            lat1     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tm_stb   <= 1'b1;
            tm_clk   <= 1'b1;
            tm_dio   <= 1'b1;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            setup    <= setup_n;
            clk_lo   <= clk_lo_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            sh       <= sh_n;
            lat0     <= lat0_n;
            lat1     <= lat1_n;
            busy     <= busy_n;
            done     <= done_n;
            tm_stb   <= stb_n;
            tm_clk   <= sclk_n;
            tm_dio   <= dio_n;
        end
    end

    // Next-state logic; line levels are derived from the next state so they stay registered.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        setup_n  = setup;
        clk_lo_n = clk_lo;
        bit_n    = bit_cnt;
        byte_n   = byte_cnt;
        sh_n     = sh;
        lat0_n   = lat0;
        lat1_n   = lat1;
        tick     = (div_cnt == DIV_LAST);

        if (state != S_IDLE) begin
            div_n = tick ? '0 : div_cnt + 8'd1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_CMD1;
                    lat0_n   = val0;
                    lat1_n   = val1;
                    div_n    = '0;
                    setup_n  = 1'b1;
                    clk_lo_n = 1'b0;
                    bit_n    = '0;
                    sh_n     = CMD_DATA;
                end
            end
            S_CMD1, S_ADDR, S_DATA, S_CMD3: begin
                if (tick) begin
                    if (setup) begin
                        setup_n  = 1'b0;
                        clk_lo_n = 1'b1;
                    end else if (clk_lo) begin
                        clk_lo_n = 1'b0;
                    end else if (bit_cnt != BIT_LAST) begin
                        // Next bit goes onto DIO together with the falling CLK.
                        bit_n    = bit_cnt + 3'd1;
                        sh_n     = {1'b0, sh[7:1]};
                        clk_lo_n = 1'b1;
                    end else begin
                        bit_n = '0;
                        case (state)
                            S_CMD1: state_n = S_GAP1;
                            S_ADDR: begin
                                state_n  = S_DATA;
                                byte_n   = '0;
                                sh_n     = ram_byte(4'h0, lat1, lat0);
                                clk_lo_n = 1'b1;
                            end
                            S_DATA: begin
                                if (byte_cnt != ADR_LAST) begin
                                    byte_n   = byte_cnt + 4'd1;
                                    sh_n     = ram_byte(byte_cnt + 4'd1, lat1, lat0);
                                    clk_lo_n = 1'b1;
                                end else begin
                                    state_n = S_GAP2;
                                end
                            end
                            default: state_n = S_GAP3;
                        endcase
                    end
                end
            end
            S_GAP1: begin
                if (tick) begin
                    state_n = S_ADDR;
                    setup_n = 1'b1;
                    sh_n    = CMD_ADDR;
                end
            end
            S_GAP2: begin
                if (tick) begin
                    state_n = S_CMD3;
                    setup_n = 1'b1;
                    sh_n    = CMD_DISP;
                end
            end
            S_GAP3: begin
                if (tick) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        slot_n = (state_n == S_CMD1) || (state_n == S_ADDR) ||
                 (state_n == S_DATA) || (state_n == S_CMD3);
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_GAP3) && (div_n == DIV_LAST);
        stb_n  = !slot_n;
        sclk_n = !(slot_n && clk_lo_n);
        dio_n  = slot_n ? sh_n[0] : 1'b1;
    end

endmodule
